// File: rtl/hilo_unit.sv
// HI/LO register file with single-cycle multiply and a 32-cycle restoring divider.
// The divider stalls the pipeline while busy and can be cancelled by flush or reset.
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  hilowe,
  input  logic [1:0]  hilochoose,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] hilo_rdata,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] hi, lo;
  logic [31:0] rem, quo, dvsr;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, div0;

  logic        wr_ok, do_mthi, do_mtlo, do_mul, do_div;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [63:0] prod_s, prod_u;
  logic [32:0] shifted, trial;
  logic        take;
  logic [31:0] rem_nx, quo_nx, quo_fix, rem_fix;

  assign wr_ok   = en && (state == IDLE);
  assign do_mthi = wr_ok && (hilowe == 2'b10) && (funct == F_MTHI);
  assign do_mtlo = wr_ok && (hilowe == 2'b10) && (funct == F_MTLO);
  assign do_mul  = wr_ok && (hilowe == 2'b11) && ((funct == F_MULT) || (funct == F_MULTU));
  assign do_div  = wr_ok && (hilowe == 2'b11) && ((funct == F_DIV) || (funct == F_DIVU));

  assign rs_neg = (funct == F_DIV) && rs_data[31];
  assign rt_neg = (funct == F_DIV) && rt_data[31];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // Sign-extending to 64 bits first makes the low 64 product bits correct for signed operands.
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  // One restoring step: the dividend shifts out of quo's MSB while quotient bits shift in.
  assign shifted = {rem, quo[31]};
  assign trial   = shifted - {1'b0, dvsr};
  assign take    = !trial[32];
  assign rem_nx  = take ? trial[31:0] : shifted[31:0];
  assign quo_nx  = {quo[30:0], take};
  assign quo_fix = neg_q ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: if (do_div) begin
        stall    = 1'b1;
        state_nx = (rt_data == '0) ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 6'd31) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush && (state != IDLE)) begin
      state_nx = IDLE;
      stall    = 1'b0;
    end
    if (rst) begin
      state_nx = IDLE;
      stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_nx;
      if (do_mthi) hi <= rs_data;
      if (do_mtlo) lo <= rs_data;
      if (do_mul) {hi, lo} <= (funct == F_MULT) ? prod_s : prod_u;
      if (do_div) begin
        rem   <= '0;
        cnt   <= '0;
        dvsr  <= rt_mag;
        div0  <= (rt_data == '0);
        // Divide-by-zero keeps the raw dividend so DONE can return it in HI.
        quo   <= (rt_data == '0) ? rs_data : rs_mag;
        neg_q <= rs_neg ^ rt_neg;
        neg_r <= rs_neg;
      end
      if (state == BUSY) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 6'd1;
      end
      if ((state == DONE) && !flush) begin
        if (div0) begin
          hi <= quo;
          lo <= '1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
    end
  end

  always_comb begin
    case (hilochoose)
      2'b11:   hilo_rdata = hi;
      2'b01:   hilo_rdata = lo;
      default: hilo_rdata = '0;
    endcase
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized self-checking bench for hilo_unit against an arithmetic HI/LO model.
module tb_hilo_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [1:0]  hilowe, hilochoose;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hilo_rdata, hi_o, lo_o;
  logic        stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  hilo_unit dut (
    .clk(clk), .rst(rst), .en(en), .hilowe(hilowe), .hilochoose(hilochoose),
    .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .hilo_rdata(hilo_rdata), .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0)                                  return {a, 32'hFFFFFFFF};
    if (!sgn)                                    return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF)  return {32'h0, 32'h80000000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic check_regs();
    for (int c = 0; c < 4; c++) begin
      hilochoose = 2'(c);
      #1;
      chk("rdata", hilo_rdata, (c == 3) ? m_hi : (c == 1) ? m_lo : 32'h0);
    end
    chk("hi_o", hi_o, m_hi);
    chk("lo_o", lo_o, m_lo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = 0;
    m_lo = 0;
    chk("stall_rst", {31'b0, stall}, 32'h0);
    check_regs();
  endtask

  task automatic simple_op(input logic e, input logic [1:0] we, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    @(negedge clk);
    en = e; hilowe = we; funct = f; rs_data = a; rt_data = b;
    #1 chk("stall_simple", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1 en = 1'b0; hilowe = 2'b00;
    if (e && we == 2'b10 && f == F_MTHI) m_hi = a;
    if (e && we == 2'b10 && f == F_MTLO) m_lo = a;
    if (e && we == 2'b11 && f == F_MULT) begin
      p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
      {m_hi, m_lo} = p;
    end
    if (e && we == 2'b11 && f == F_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      {m_hi, m_lo} = p;
    end
    check_regs();
  endtask

  // abort: 0 none, 1 flush at BUSY cycle 10, 2 rst at BUSY cycle 10, 3 flush in DONE
  task automatic div_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int abort, input bit inj);
    int n;
    bit aborted;
    aborted = 0;
    @(negedge clk);
    en = 1'b1; hilowe = 2'b11; funct = sgn ? F_DIV : F_DIVU; rs_data = a; rt_data = b;
    #1 chk("stall_accept", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1 en = 1'b0; hilowe = 2'b00; funct = 6'h0;
    n = 1;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      en = 1'b0; hilowe = 2'b00;
      if (inj && n == 6) begin
        en = 1'b1; hilowe = 2'b10; funct = F_MTLO; rs_data = $urandom;
      end
      if ((abort == 1 || abort == 2) && n == 11) begin
        if (abort == 1) flush = 1'b1; else rst = 1'b1;
        #1 chk("stall_abort", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1 flush = 1'b0; rst = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clk);
    end
    en = 1'b0; hilowe = 2'b00;
    if (aborted) begin
      if (abort == 2) begin m_hi = 0; m_lo = 0; end
    end else begin
      chk("stall_len", 32'(n), (b == 0) ? 32'd1 : 32'd33);
      if (abort == 3) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      if (abort != 3) {m_hi, m_lo} = ref_div(sgn, a, b);
    end
    chk("stall_after", {31'b0, stall}, 32'h0);
    check_regs();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; hilowe = 2'b00; hilochoose = 2'b00;
    funct = 6'h0; rs_data = 0; rt_data = 0;
    m_hi = 0; m_lo = 0;
    do_reset();

    simple_op(1, 2'b10, F_MTHI, 32'h12345678, 0);
    simple_op(1, 2'b10, F_MTLO, 32'hCAFEF00D, 0);
    simple_op(1, 2'b11, F_MULT, 32'hFFFFFFFE, 3);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFFA);
    simple_op(1, 2'b11, F_MULTU, 32'hFFFFFFFE, 3);
    chk("multu_hi", hi_o, 32'h00000002);

    div_op(1, -32'sd7, 32'd2, 0, 0);
    chk("div_lo", lo_o, 32'hFFFFFFFD);
    chk("div_hi", hi_o, 32'hFFFFFFFF);
    div_op(0, 32'd100, 32'd7, 0, 0);
    chk("divu_lo", lo_o, 32'd14);
    div_op(0, 32'h55, 32'h0, 0, 0);
    chk("div0_lo", lo_o, 32'hFFFFFFFF);
    div_op(1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    div_op(1, 32'h1234, 32'd5, 1, 0);
    div_op(1, 32'h1234, 32'd5, 3, 0);
    div_op(1, 32'h1234, 32'd5, 2, 0);
    simple_op(1, 2'b10, F_MTLO, 32'h0BADBEEF, 0);
    div_op(0, 32'd1000, 32'd9, 0, 1);

    simple_op(0, 2'b10, F_MTHI, 32'hDEADBEEF, 0);
    simple_op(1, 2'b00, F_MTHI, 32'hDEADBEEF, 0);
    simple_op(1, 2'b11, F_MTHI, 32'hDEADBEEF, 0);
    simple_op(1, 2'b11, F_MFLO, 32'hDEADBEEF, 1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: simple_op(1, 2'b10, F_MTHI, $urandom, 0);
        1: simple_op(1, 2'b10, F_MTLO, $urandom, 0);
        2: simple_op(1, 2'b11, F_MULT, pick(), pick());
        3: simple_op(1, 2'b11, F_MULTU, pick(), pick());
        4: simple_op(1'($urandom), 2'($urandom), F_MFHI, $urandom, $urandom);
        5: simple_op(0, 2'b11, F_MULT, $urandom, $urandom);
        6: do_reset();
        default: div_op(1'($urandom), pick(), pick(),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                        1'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 en  input  1  EX-stage instruction valid; when 0, hilowe and funct are ignored.
REQ-004 hilowe  input  2  bit1 = HI/LO write enable; bit0 = source (1 mul/div result, 0 register rs_data).
REQ-005 hilochoose  input  2  read select: 2'b11 HI, 2'b01 LO, others 0.
REQ-006 funct  input  6  instruction funct field.
REQ-007 rs_data, rt_data  input  32 each  operands; signed or unsigned per funct.
REQ-008 flush  input  1  cancels an in-flight divide.
REQ-009 hilo_rdata  output  32  HI/LO read data for MFHI/MFLO.
REQ-010 stall  output  1  holds the pipeline while a divide is busy.
REQ-011 hi_o, lo_o  output  32 each  current register contents.

Function
REQ-012 Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
REQ-013 hilo_rdata is combinational: HI when hilochoose=11, LO when 01, 0 otherwise; no same-cycle write bypass.
REQ-014 en=1, hilowe=2'b10, funct=MTHI: HI <= rs_data at the next edge; LO unchanged.
REQ-015 en=1, hilowe=2'b10, funct=MTLO: LO <= rs_data at the next edge; HI unchanged.
REQ-016 en=1, hilowe=2'b11, funct MULT/MULTU: {HI,LO} <= 64-bit signed/unsigned product of rs_data*rt_data at the next edge; stall stays 0.
REQ-017 en=1, hilowe=2'b11, funct DIV/DIVU in IDLE: operands latched and FSM goes to BUSY; stall asserts combinationally in the accept cycle.
REQ-018 FSM states: IDLE, BUSY, DONE. IDLE->BUSY on accept; BUSY runs a 32-iteration restoring divide, one quotient bit per cycle, tracked by a 6-bit counter; BUSY->DONE after the 32nd iteration; DONE->IDLE after one cycle.
REQ-019 In DONE: LO <= quotient, HI <= remainder; stall deasserts in DONE. Total stall = 33 cycles (accept cycle plus 32 BUSY cycles).
REQ-020 Signed divide: operate on magnitudes. Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.
REQ-021 Divide by zero: no iteration; FSM goes directly to DONE; HI <= dividend, LO <= 32'hFFFFFFFF; stall = 1 cycle.
REQ-022 Signed 0x80000000 / -1: LO <= 0x80000000, HI <= 0 (wrap, no trap).
REQ-023 flush in BUSY or DONE: FSM goes to IDLE next edge, HI/LO unchanged, stall deasserts that cycle; flush in IDLE has no effect.
REQ-024 Write requests (REQ-014..017) that arrive while the FSM is not IDLE are ignored; the pipeline guarantees they are held by stall.
REQ-025 hilowe with bit1=0 never writes HI/LO.
REQ-026 Other hilowe=2'b11 funct values: no write, no state change.

Reset
REQ-027 rst=1 at an edge: HI=0, LO=0, FSM=IDLE, counter=0, stall=0, hilo_rdata reflects the zeroed registers.
REQ-028 rst during BUSY aborts the divide the same way and takes priority over flush and over new requests.

Verification
REQ-029 MTHI rs=0x12345678, then MFHI (hilochoose=11) -> hilo_rdata=0x12345678; LO unchanged.
REQ-030 MULT rs=0xFFFFFFFE (-2), rt=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 DIV rs=-7, rt=2 -> stall high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 -> LO=14, HI=2.
REQ-032 DIVU rs=0x55, rt=0 -> stall 1 cycle; HI=0x55, LO=0xFFFFFFFF.
REQ-033 DIV accepted, flush at BUSY cycle 10 -> stall drops, HI/LO retain their prior values. Repeat with rst instead of flush -> HI=LO=0.
REQ-034 MTLO issued during BUSY -> ignored; LO = quotient after DONE.
